// File: rtl/vga_fb_arbiter.sv
// Framebuffer memory arbiter: shares one single-port memory between the
// display prefetch FIFO and a CPU port. The grant for the next cycle is
// decided at each clock edge from the post-edge FIFO level, so every
// memory strobe is driven straight from the registered state.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no memory access this cycle (also used for out-of-range CPU)
//   DISP  | display read at fetch_addr; data returns next cycle
//   CPU   | CPU read/write at cpu_addr; cpu_ack follows next cycle
module vga_fb_arbiter #(
  parameter int FIFO_DEPTH = 8,
  parameter int LOW_WATER  = 4,
  parameter int FB_WORDS   = 307200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [18:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [31:0] cpu_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [18:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        disp_frame_start,
  input  logic        disp_rd,
  output logic [23:0] disp_pixel,
  output logic        disp_underrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = CW + 1;
  localparam logic [31:0] FB_LIM    = 32'(FB_WORDS);
  localparam logic [31:0] DEPTH_LIM = 32'(FIFO_DEPTH);
  localparam logic [31:0] LOW_LIM   = 32'(LOW_WATER);

  typedef enum logic [1:0] {IDLE, DISP, CPU} state_t;

  state_t        state, state_nxt;
  logic          cpu_oob, cpu_oob_nxt;
  logic          cpu_rd_q;
  logic          disp_inflight, inflight_nxt;
  logic [18:0]   fetch_addr, fetch_addr_nxt;
  logic [CW-1:0] occ, occ_nxt;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [23:0]   fifo_mem [FIFO_DEPTH];
  logic [LW-1:0] level_nxt;
  logic          push, pop, urgent, fetch_done_nxt, cpu_pending, cpu_in_range;

  // Post-edge FIFO bookkeeping; frame start overrides any push/pop/issue
  always_comb begin
    push           = disp_inflight & ~disp_frame_start;
    pop            = disp_rd & (occ != '0) & ~disp_frame_start;
    inflight_nxt   = (state == DISP) & ~disp_frame_start;
    occ_nxt        = disp_frame_start ? '0 : occ + CW'(push) - CW'(pop);
    fetch_addr_nxt = fetch_addr;
    if (disp_frame_start)   fetch_addr_nxt = '0;
    else if (state == DISP) fetch_addr_nxt = fetch_addr + 19'd1;
    level_nxt      = {1'b0, occ_nxt} + LW'(inflight_nxt);
    fetch_done_nxt = {13'b0, fetch_addr_nxt} >= FB_LIM;
    urgent         = 32'(level_nxt) < LOW_LIM;
    cpu_pending    = (state == CPU) | cpu_oob | cpu_ack;
    cpu_in_range   = {13'b0, cpu_addr} < FB_LIM;
  end

  // Grant priority for the next cycle
  always_comb begin
    state_nxt   = IDLE;
    cpu_oob_nxt = 1'b0;
    if (urgent && !fetch_done_nxt) begin
      state_nxt = DISP;
    end else if (cpu_req && !cpu_pending) begin
      if (cpu_in_range) state_nxt   = CPU;
      else              cpu_oob_nxt = 1'b1;
    end else if (32'(level_nxt) < DEPTH_LIM && !fetch_done_nxt) begin
      state_nxt = DISP;
    end
  end

  // State, CPU handshake and FIFO control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cpu_oob       <= 1'b0;
      cpu_ack       <= 1'b0;
      cpu_rd_q      <= 1'b0;
      disp_inflight <= 1'b0;
      fetch_addr    <= '0;
      occ           <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      disp_underrun <= 1'b0;
    end else begin
      state         <= state_nxt;
      cpu_oob       <= cpu_oob_nxt;
      cpu_ack       <= (state == CPU) | cpu_oob;
      cpu_rd_q      <= (state == CPU) & ~cpu_we;
      disp_inflight <= inflight_nxt;
      fetch_addr    <= fetch_addr_nxt;
      occ           <= occ_nxt;
      if (disp_frame_start) begin
        rd_ptr        <= '0;
        wr_ptr        <= '0;
        disp_underrun <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (disp_rd && occ == '0) disp_underrun <= 1'b1;
      end
    end
  end

  // Pixel storage; contents are don't-care while the FIFO is empty
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_rdata[23:0];
  end

  // Memory strobes and read-data steering
  always_comb begin
    mem_en     = (state != IDLE);
    mem_we     = (state == CPU) & cpu_we;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (state == DISP)     mem_addr = fetch_addr;
    else if (state == CPU) mem_addr = cpu_addr;
    if (state == CPU && cpu_we) mem_wdata = cpu_wdata;
    cpu_rdata  = (cpu_ack && cpu_rd_q) ? mem_rdata : '0;
    disp_pixel = (occ != '0) ? fifo_mem[rd_ptr] : '0;
  end

endmodule
